// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pipe_pkg                                                     |
// | Description : Shared pipeline constants: stage indices, default field      |
// |               widths and the per-stage control bundle.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pipe_pkg;

    // Stage register indices, youngest first
    localparam int ST_IF_ID   = 0;
    localparam int ST_ID_EXE  = 1;
    localparam int ST_EXE_MEM = 2;
    localparam int ST_MEM_WB  = 3;

    // Default field widths of the surrounding core
    localparam int PC_W   = 32;
    localparam int RN_W   = 5;
    localparam int ALUC_W = 3;

    // Default chain geometry
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_CNT_W  = 16;

    // Per-stage update controls, listed in priority order
    typedef struct packed {
        logic kill;
        logic hold;
        logic bub;
        logic ld;
    } stage_ctrl_t;

    // Build the control bundle; a plain load only happens when nothing
    // of higher priority applies.
    function automatic stage_ctrl_t stage_ctrl(input logic kill,
                                               input logic hold,
                                               input logic bub);
        stage_ctrl_t c;
        c.kill = kill;
        c.hold = hold;
        c.bub  = bub;
        c.ld   = ~(kill | hold | bub);
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg_chain_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : pipe_reg_chain_if                                            |
// | Description : Input offer, hazard requests and stage/output observation    |
// |               bus of the pipeline register chain. Counter signals exist    |
// |               only when PIPE_PERF_EN is defined.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pipe_reg_chain_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic                       in_ready;
    logic [STAGES-1:0]          stall_req;
    logic [STAGES-1:0]          flush_req;
    logic [STAGES-1:0]          stage_valid;
    logic [STAGES*DATA_W-1:0]   stage_data;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0]           stall_cnt;
    logic [CNT_W-1:0]           flush_cnt;
`endif

`ifdef PIPE_PERF_EN
    modport master (
        output in_valid, in_data, stall_req, flush_req,
        input  in_ready, stage_valid, stage_data, out_valid, out_data,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  in_valid, in_data, stall_req, flush_req,
        output in_ready, stage_valid, stage_data, out_valid, out_data,
        output stall_cnt, flush_cnt
    );
`else
    modport master (
        output in_valid, in_data, stall_req, flush_req,
        input  in_ready, stage_valid, stage_data, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, stall_req, flush_req,
        output in_ready, stage_valid, stage_data, out_valid, out_data
    );
`endif

endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_reg                                               |
// | Description : One pipeline register (valid + payload) with kill, hold,    |
// |               bubble and load controls applied in that priority order.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_reg #(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_ld,
    input  wire logic              i_hold,
    input  wire logic              i_kill,
    input  wire logic              i_bub,
    input  wire logic              i_valid,
    input  wire logic [DATA_W-1:0] i_data,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Kill and bubble both leave an empty, zeroed slot; hold keeps contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_kill) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_hold) begin
            r_valid <= r_valid;
            r_data  <= r_data;
        end else if (i_bub) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_ld) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_reg_chain                                               |
// | Description : Parametrised chain of pipeline registers (IF/ID .. MEM/WB)  |
// |               with per-stage stall and flush. Register 0 is the youngest. |
// |               Build option PIPE_PERF_EN adds saturating stall/flush cycle  |
// |               counters.                                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int STAGES = DEF_STAGES,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    pipe_reg_chain_if.slave  bus
);

    logic [STAGES-1:0]          w_hold;
    logic [STAGES-1:0]          w_kill;
    logic [STAGES-1:0]          w_bub;
    stage_ctrl_t [STAGES-1:0]   w_ctrl;
    logic [STAGES-1:0]          w_valid;
    logic [STAGES*DATA_W-1:0]   w_data;

    // An older stall or flush reaches every younger stage, so each stage
    // looks at the OR of its own request and all requests above it.
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic              w_d_valid;
            logic [DATA_W-1:0] w_d_data;

            assign w_hold[k] = |bus.stall_req[STAGES-1:k];
            assign w_kill[k] = |bus.flush_req[STAGES-1:k];

            if (k == 0) begin : g_head
                // Offers without valid load a clean, zero-payload bubble
                assign w_bub[k]  = 1'b0;
                assign w_d_valid = bus.in_valid;
                assign w_d_data  = bus.in_valid ? bus.in_data : '0;
            end else begin : g_body
                // A stalled predecessor sends a bubble into this stage
                assign w_bub[k]  = bus.stall_req[k-1];
                assign w_d_valid = w_valid[k-1];
                assign w_d_data  = w_data[(k-1)*DATA_W +: DATA_W];
            end

            assign w_ctrl[k] = stage_ctrl(w_kill[k], w_hold[k], w_bub[k]);

            pipe_stage_reg #(
                .DATA_W (DATA_W)
            ) u_stage_reg (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_ld    (w_ctrl[k].ld),
                .i_hold  (w_ctrl[k].hold),
                .i_kill  (w_ctrl[k].kill),
                .i_bub   (w_ctrl[k].bub),
                .i_valid (w_d_valid),
                .i_data  (w_d_data),
                .o_valid (w_valid[k]),
                .o_data  (w_data[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // The only combinational output: register 0 accepts unless held or killed
    assign bus.in_ready    = ~w_hold[0] & ~w_kill[0];
    assign bus.stage_valid = w_valid;
    assign bus.stage_data  = w_data;
    assign bus.out_valid   = w_valid[STAGES-1];
    assign bus.out_data    = w_data[(STAGES-1)*DATA_W +: DATA_W];

`ifdef PIPE_PERF_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Count cycles with any stall request, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((|bus.stall_req) && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Count cycles with any flush request, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
        end else if ((|bus.flush_req) && (r_flush_cnt != c_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
